// File: rtl/serial_cla_ctrl.sv
// Multi-cycle adder: one SLICE-bit carry-lookahead slice is reused for
// WIDTH/SLICE cycles, least-significant slice first, with a registered carry.
module serial_cla_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [IDXW-1:0]   idx;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              cout_q, ovf_q;

  logic [SLICE-1:0]  sa, sb, sg, sp, ssum;
  logic [SLICE:0]    c;
  logic              last;

  // Lookahead carries inside the current slice, seeded by the registered carry.
  always_comb begin
    sa   = a_q[idx*SLICE +: SLICE];
    sb   = b_q[idx*SLICE +: SLICE];
    sg   = sa & sb;
    sp   = sa ^ sb;
    c    = '0;
    c[0] = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      c[i+1] = sg[i] | (sp[i] & c[i]);
    end
    ssum = sp ^ c[SLICE-1:0];
  end

  assign last = (idx == LAST_IDX);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          idx     <= '0;
          sum_q   <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        RUN: begin
          sum_q[idx*SLICE +: SLICE] <= ssum;
          carry_q <= c[SLICE];
          idx     <= idx + 1'b1;
          if (last) begin
            cout_q <= c[SLICE];
            ovf_q  <= c[SLICE-1] ^ c[SLICE];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_cla_ctrl.sv
// Directed bench for serial_cla_ctrl (WIDTH=32, SLICE=4): vector table plus
// hand-written reset, backpressure and back-to-back sequences.
module tb_serial_cla_ctrl;
  localparam int W = 32;
  localparam int NS = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  serial_cla_ctrl #(.WIDTH(W), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set, waits for the result, checks latency and value,
  // then completes the output handshake. Called one step after a rising edge.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                        input logic [W-1:0] esum, input logic ecout, input logic eovf,
                        input logic keep_ready);
    int lat;
    logic [W-1:0] e;
    out_ready = keep_ready;
    check("idle_before_op", {31'd0, in_ready}, 1);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    exp_q.push_back(esum);
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("latency", lat, NS);
    e = exp_q.pop_front();
    check("sum", sum, e);
    check("cout", {31'd0, cout}, {31'd0, ecout});
    check("ovf", {31'd0, ovf}, {31'd0, eovf});
    out_ready = 1'b1;
    tick();
    check("out_valid_drop", {31'd0, out_valid}, 0);
    check("in_ready_after", {31'd0, in_ready}, 1);
    out_ready = keep_ready;
  endtask

  initial begin
    vecs[0] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[6] = '{32'h89ABCDEF, 32'h12345678, 1'b0, 32'h9BE02467, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};

    // Reset with in_valid asserted must not accept.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 32'h5; b = 32'h3; cin = 1'b1;
    repeat (2) tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", {31'd0, cout}, 0);
    check("rst_ovf", {31'd0, ovf}, 0);
    tick();
    check("rst_still_idle", {31'd0, in_ready}, 1);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b0);
    end

    // Backpressure: result held while out_ready is low, new operands ignored.
    out_ready = 1'b0;
    a = 32'h7FFFFFFF; b = 32'h1; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < NS; i++) tick();
    check("bp_out_valid0", {31'd0, out_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = $urandom; b = $urandom;
      tick();
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      check("bp_sum", sum, 32'h80000000);
      check("bp_cout", {31'd0, cout}, 0);
      check("bp_ovf", {31'd0, ovf}, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", {31'd0, in_ready}, 1);
    check("bp_release_out_valid", {31'd0, out_valid}, 0);

    // Reset during the fourth RUN cycle.
    a = 32'h12345678; b = 32'h11111111; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("mid_sum_partial", sum, 32'h0000078A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", {31'd0, in_ready}, 1);
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_sum", sum, 0);
    run_op(32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0);

    // Back-to-back with out_ready tied high.
    run_op(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b1);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
